// File: rtl/sevenseg_capture.sv
// sevenseg_capture: recovers BCD digits from a scanned, active-low 4-digit seven-segment bus.
// Latency: a pin change first sampled at edge k drives capture effects at edge k+1+STABLE_CYCLES.
// Backpressure: none; the bus is sampled every cycle and each completed frame is strobed once.
module sevenseg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cathode,
  input  logic [3:0] anode,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       signal_lost
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    RUN_HIT  = 8'(STABLE_CYCLES);
  localparam logic [7:0]    RUN_MAX  = 8'hFF;
  localparam logic [7:0]    RUN_ONE  = 8'd1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  // synchronizer and stability tracking
  logic [11:0]      r_sync1;
  logic [11:0]      r_sync2;
  logic [11:0]      r_prev;
  logic [7:0]       r_run;

  // frame assembly
  logic [3:0]       r_seen;
  logic [3:0][3:0]  r_shadow;

  // loss-of-signal tracking
  logic [TW-1:0]    r_tmo;

  logic             w_changed;
  logic [7:0]       w_run;
  logic             w_hit;
  logic             w_one_cold;
  logic [1:0]       w_idx;
  logic [6:0]       w_seg;
  logic             w_legal;
  logic [3:0]       w_digit;
  logic             w_capture;
  logic             w_cap_legal;
  logic             w_cap_illegal;
  logic [3:0]       w_seen_next;
  logic             w_frame_done;
  logic             w_tmo_expire;
  logic [3:0][3:0]  w_frame;

  // Two-flop synchronizer on the whole pin bus; the bus may come from another clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {anode, cathode};
      r_sync2 <= r_sync1;
    end
  end

  // The run length seen this cycle: 1 on any change of the synchronized bus, else one more, capped.
  assign w_changed = (r_sync2 != r_prev);
  assign w_run     = w_changed ? RUN_ONE : ((r_run == RUN_MAX) ? RUN_MAX : (r_run + RUN_ONE));

  // Fire exactly once per stable period, on the cycle the run first reaches the threshold;
  // checking the previous run keeps a threshold of 255 from firing again while saturated.
  assign w_hit = (w_run == RUN_HIT) && (r_run != RUN_HIT);

  // Remember the previous sample and the run length for the next comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_run  <= '0;
    end else begin
      r_prev <= r_sync2;
      r_run  <= w_run;
    end
  end

  // Only a single low anode names a digit; blank scans and ghosting overlaps are ignored.
  always_comb begin
    w_one_cold = 1'b1;
    w_idx      = 2'd0;
    case (r_sync2[11:8])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_one_cold = 1'b0;
    endcase
  end

  // Segment pattern (lit = 1, gfedcba) back to BCD; all-off decodes as the blank digit F.
  assign w_seg = ~r_sync2[6:0];

  // Map each legal glyph to its digit and flag anything else.
  always_comb begin
    w_legal = 1'b1;
    w_digit = 4'hF;
    case (w_seg)
      7'h3F:   w_digit = 4'd0;
      7'h06:   w_digit = 4'd1;
      7'h5B:   w_digit = 4'd2;
      7'h4F:   w_digit = 4'd3;
      7'h66:   w_digit = 4'd4;
      7'h6D:   w_digit = 4'd5;
      7'h7D:   w_digit = 4'd6;
      7'h07:   w_digit = 4'd7;
      7'h7F:   w_digit = 4'd8;
      7'h6F:   w_digit = 4'd9;
      7'h00:   w_digit = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_capture     = w_hit && w_one_cold;
  assign w_cap_legal   = w_capture && w_legal;
  assign w_cap_illegal = w_capture && !w_legal;
  assign w_seen_next   = r_seen | (4'b0001 << w_idx);
  assign w_frame_done  = w_cap_legal && (w_seen_next == 4'hF);

  // Timeout fires on the edge the idle count reaches its limit; a capture on that edge wins.
  assign w_tmo_expire  = !w_capture && (r_tmo == TMO_LAST);

  // The frame to publish: the shadows with the digit being captured this cycle merged in.
  always_comb begin
    w_frame        = r_shadow;
    w_frame[w_idx] = w_digit;
  end

  // Shadow digits and the set of positions captured since the last frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen   <= '0;
      r_shadow <= '0;
    end else if (w_cap_legal) begin
      r_shadow[w_idx] <= w_digit;
      r_seen          <= w_frame_done ? 4'h0 : w_seen_next;
    end else if (w_tmo_expire) begin
      r_seen <= '0;
    end
  end

  // Publish a complete frame and emit the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones        <= '0;
      tens        <= '0;
      hundreds    <= '0;
      thousands   <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      frame_valid <= w_frame_done;
      seg_err     <= w_cap_illegal;
      if (w_frame_done) begin
        ones      <= w_frame[0];
        tens      <= w_frame[1];
        hundreds  <= w_frame[2];
        thousands <= w_frame[3];
      end
    end
  end

  // Count idle cycles since the last capture of any kind, holding at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_capture) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + TMO_ONE;
    end
  end

  // Loss of signal: raised by reset or timeout, dropped only by a legal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_lost <= 1'b1;
    end else if (w_cap_legal) begin
      signal_lost <= 1'b0;
    end else if (w_tmo_expire) begin
      signal_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed scans of the seven-segment bus against a behavioural model.
// Latency: outputs compared every cycle at the falling edge; literal checks after each scenario.
// Backpressure: none; the bench drives pins freely and the DUT has no ready handshake.
`timescale 1ns/1ps
module tb_sevenseg_capture;

  localparam int N = 16;
  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cathode;
  logic [3:0] anode;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic       frame_valid;
  logic       seg_err;
  logic       signal_lost;

  always #5 clk = ~clk;

  sevenseg_capture #(
    .STABLE_CYCLES (N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cathode    (cathode),
    .anode      (anode),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .frame_valid(frame_valid),
    .seg_err    (seg_err),
    .signal_lost(signal_lost)
  );

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lit segments (gfedcba) for each decimal glyph.
  function automatic logic [6:0] seg_on(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Cathode pins for a digit (15 = blank); dp kept off.
  function automatic logic [7:0] cath_of(input int d);
    logic [6:0] p;
    p = seg_on(d);
    if (d == 15) return 8'hFF;
    return {1'b1, ~p};
  endfunction

  // ---------------- behavioural model ----------------
  logic [11:0] m_prev;
  int          m_run;
  int          m_cyc;
  int          m_last;
  bit          m_lostf;
  logic [3:0]  m_seen;
  logic [3:0]  m_sh  [4];
  logic [3:0]  m_out [4];
  bit          m_fv;
  bit          m_se;
  bit          pv [2];
  bit          pl [2];
  int          pi [2];
  logic [3:0]  pd [2];

  task automatic model_reset();
    m_prev  = '0;
    m_run   = 0;
    m_last  = m_cyc;
    m_lostf = 1'b1;
    m_seen  = '0;
    m_fv    = 1'b0;
    m_se    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '0;
      m_out[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pl[i] = 1'b0; pi[i] = 0; pd[i] = '0;
    end
  endtask

  task automatic decode(input logic [6:0] lit, output bit legal, output logic [3:0] d);
    legal = (lit == 7'h00);
    d     = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (seg_on(k) == lit) begin
        legal = 1'b1;
        d     = 4'(k);
      end
    end
  endtask

  task automatic apply(input bit legal, input int pos, input logic [3:0] d);
    if (m_cyc - m_last > T) begin
      m_seen  = '0;
      m_lostf = 1'b1;
    end
    m_last = m_cyc;
    if (legal) begin
      m_sh[pos]   = d;
      m_seen[pos] = 1'b1;
      m_lostf     = 1'b0;
      if (m_seen == 4'hF) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
        m_fv   = 1'b1;
        m_seen = '0;
      end
    end else begin
      m_se = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [11:0] smp;
    bit          legal;
    logic [3:0]  d;
    m_cyc++;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (pv[1]) apply(pl[1], pi[1], pd[1]);
    pv[1] = pv[0]; pl[1] = pl[0]; pi[1] = pi[0]; pd[1] = pd[0];
    smp = {anode, cathode};
    if (smp == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = smp;
    pv[0]  = 1'b0;
    if (m_run == N && $countones(~anode) == 1) begin
      decode(~cathode[6:0], legal, d);
      pv[0] = 1'b1;
      pl[0] = legal;
      pd[0] = d;
      for (int i = 0; i < 4; i++) if (!anode[i]) pi[0] = i;
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic exp_lost;
    forever begin
      @(negedge clk);
      exp_lost = m_lostf || (m_cyc - m_last >= T);
      chk("cycle", 32'({thousands, hundreds, tens, ones, frame_valid, seg_err, signal_lost}),
          32'({m_out[3], m_out[2], m_out[1], m_out[0], m_fv, m_se, exp_lost}));
    end
  end

  // Pulse counters for the literal scenario checks.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid) fv_cnt++;
      if (seg_err) se_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] an, input logic [7:0] ca, input int n);
    anode   = an;
    cathode = ca;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input int d, input int n);
    drive(~(4'b0001 << pos), cath_of(d), n);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 8'hFF, n);
  endtask

  task automatic chk_digits(input string name, input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on);
    chk(name, 32'({thousands, hundreds, tens, ones}), 32'({th, hu, te, on}));
  endtask

  initial begin
    rst_n   = 1'b1;
    anode   = 4'hF;
    cathode = 8'hFF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_digits("reset_digits", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    chk("reset_seg_err", 32'(seg_err), 32'd0);
    chk("reset_lost", 32'(signal_lost), 32'd1);
    rst_n = 1'b1;

    // frame capture
    show(0, 4, 40);
    chk("lost_after_first", 32'(signal_lost), 32'd0);
    show(1, 3, 40); show(2, 2, 40); show(3, 1, 40); idle(5);
    chk("frame1_cnt", 32'(fv_cnt), 32'd1);
    chk_digits("frame1_digits", 4'd1, 4'd2, 4'd3, 4'd4);

    // glitch rejection: blank gaps and short wrong-glyph glitches
    show(0, 5, 40); idle(10); show(1, 0, 5); show(1, 6, 40);
    idle(10); show(2, 0, 5); show(2, 7, 40);
    idle(10); show(3, 0, 5); show(3, 8, 40); idle(5);
    chk("glitch_cnt", 32'(fv_cnt), 32'd2);
    chk("glitch_seg_err", 32'(se_cnt), 32'd0);
    chk_digits("glitch_digits", 4'd8, 4'd7, 4'd6, 4'd5);

    // illegal glyph on ones must not mark ones as seen
    drive(4'b1110, {1'b1, ~7'h49}, 30); idle(3);
    chk("illegal_seg_err", 32'(se_cnt), 32'd1);
    chk("illegal_no_fv", 32'(fv_cnt), 32'd2);
    show(1, 7, 40); show(2, 8, 40); show(3, 9, 40); idle(5);
    chk("illegal_seen_kept", 32'(fv_cnt), 32'd2);
    show(0, 5, 40); idle(5);
    chk("illegal_frame_cnt", 32'(fv_cnt), 32'd3);
    chk_digits("illegal_digits", 4'd9, 4'd8, 4'd7, 4'd5);

    // blank and re-capture of ones
    show(0, 5, 40); show(0, 15, 40); show(1, 0, 40); show(2, 6, 40); show(3, 2, 40); idle(5);
    chk("blank_cnt", 32'(fv_cnt), 32'd4);
    chk_digits("blank_digits", 4'd2, 4'd6, 4'd0, 4'hF);

    // timeout: partial frame is discarded
    show(0, 3, 40); show(1, 4, 40);
    idle(170);
    chk("tmo_not_yet", 32'(signal_lost), 32'd0);
    idle(15);
    chk("tmo_lost", 32'(signal_lost), 32'd1);
    idle(20);
    show(2, 1, 40); show(3, 2, 40); idle(5);
    chk("tmo_no_reuse", 32'(fv_cnt), 32'd4);
    show(0, 3, 40); show(1, 4, 40); idle(5);
    chk("tmo_frame_cnt", 32'(fv_cnt), 32'd5);
    chk_digits("tmo_digits", 4'd2, 4'd1, 4'd4, 4'd3);
    chk("tmo_lost_clear", 32'(signal_lost), 32'd0);

    // reset mid-frame
    show(0, 1, 40); show(1, 2, 40); show(2, 3, 40); idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk_digits("rst_mid_digits", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("rst_mid_lost", 32'(signal_lost), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    show(3, 4, 40); idle(5);
    chk("rst_mid_no_fv", 32'(fv_cnt), 32'd5);
    show(0, 1, 40); show(1, 2, 40); idle(5);
    chk("rst_mid_partial", 32'(fv_cnt), 32'd5);
    show(2, 3, 40); idle(5);
    chk("rst_mid_frame_cnt", 32'(fv_cnt), 32'd6);
    chk_digits("rst_mid_digits2", 4'd4, 4'd3, 4'd2, 4'd1);
    chk("total_seg_err", 32'(se_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
